// File: rtl/vfifo_mq_pkg.sv
// Shared constants and types for the multi-queue FIFO: default geometry,
// per-queue depth, RAM address width and the wrap-bit pointer type.
package vfifo_mq_pkg;
  localparam int DATA_WIDTH_DEF   = 32;
  localparam int Q_ADDR_WIDTH_DEF = 4;
  localparam int QSEL_WIDTH_DEF   = 2;
  localparam int NR_QUEUES_DEF    = 4;
  localparam int Q_DEPTH          = 1 << Q_ADDR_WIDTH_DEF;
  localparam int RAM_ADDR_WIDTH   = QSEL_WIDTH_DEF + Q_ADDR_WIDTH_DEF;

  typedef logic [Q_ADDR_WIDTH_DEF:0] ptr_t;
endpackage

// File: rtl/vfifo_mq_sc_if.sv
// Write/read/status bundle between the FIFO core and the arbiter/DMA layer.
interface vfifo_mq_sc_if
  import vfifo_mq_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int QSEL_WIDTH = QSEL_WIDTH_DEF,
  parameter int NR_QUEUES  = NR_QUEUES_DEF
);
  logic                  wr_en;
  logic [QSEL_WIDTH-1:0] wr_q;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [QSEL_WIDTH-1:0] rd_q;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic [NR_QUEUES-1:0]  full;
  logic [NR_QUEUES-1:0]  empty;
  logic [NR_QUEUES-1:0]  ovf;
  logic [NR_QUEUES-1:0]  udf;
  logic                  err_clr;

  modport master (
    output wr_en, wr_q, wr_data, rd_en, rd_q, err_clr,
    input  rd_data, rd_valid, full, empty, ovf, udf
  );

  modport slave (
    input  wr_en, wr_q, wr_data, rd_en, rd_q, err_clr,
    output rd_data, rd_valid, full, empty, ovf, udf
  );
endinterface

// File: rtl/vfifo_simple_dpram_sc.sv
// Simple dual-port RAM, one clock: one write port, one read port with an
// output register that only loads on a read. No reset on storage or output.
module vfifo_simple_dpram_sc #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);
  logic [DATA_WIDTH-1:0] mem [1 << ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/vfifo_mq_sc.sv
// Multi-queue FIFO core: per-queue wrap-bit pointers over a shared RAM,
// flags decoded from registered pointers, sticky overflow/underflow.
module vfifo_mq_sc
  import vfifo_mq_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int Q_ADDR_WIDTH = Q_ADDR_WIDTH_DEF,
  parameter int QSEL_WIDTH   = QSEL_WIDTH_DEF,
  parameter int NR_QUEUES    = NR_QUEUES_DEF
) (
  input logic          clk,
  input logic          rst,
  vfifo_mq_sc_if.slave bus
);
  localparam int AW = QSEL_WIDTH + Q_ADDR_WIDTH;
  localparam int QS = 1 << QSEL_WIDTH;
  localparam logic [QSEL_WIDTH:0] NQ = NR_QUEUES[QSEL_WIDTH:0];

  logic [Q_ADDR_WIDTH:0]   wr_ptr [NR_QUEUES];
  logic [Q_ADDR_WIDTH:0]   rd_ptr [NR_QUEUES];
  logic [NR_QUEUES-1:0]    full, empty, ovf, udf;
  logic [NR_QUEUES-1:0]    ovf_set, udf_set;
  logic [QS-1:0]           full_x, empty_x;
  logic [Q_ADDR_WIDTH-1:0] wr_lo, rd_lo;
  logic                    wr_in_rng, rd_in_rng, wr_ok, rd_ok;
  logic                    vld_p1, seen_p1;
  logic [DATA_WIDTH-1:0]   ram_q_p1;

  always_comb begin
    full  = '0;
    empty = '0;
    wr_lo = '0;
    rd_lo = '0;
    for (int i = 0; i < NR_QUEUES; i++) begin
      empty[i] = (wr_ptr[i] == rd_ptr[i]);
      full[i]  = (wr_ptr[i][Q_ADDR_WIDTH] != rd_ptr[i][Q_ADDR_WIDTH]) &&
                 (wr_ptr[i][Q_ADDR_WIDTH-1:0] == rd_ptr[i][Q_ADDR_WIDTH-1:0]);
      if (bus.wr_q == QSEL_WIDTH'(i)) wr_lo = wr_ptr[i][Q_ADDR_WIDTH-1:0];
      if (bus.rd_q == QSEL_WIDTH'(i)) rd_lo = rd_ptr[i][Q_ADDR_WIDTH-1:0];
    end
  end

  // Flags are widened to the full select range so any select indexes safely.
  assign full_x    = QS'(full);
  assign empty_x   = QS'(empty);
  assign wr_in_rng = ({1'b0, bus.wr_q} < NQ);
  assign rd_in_rng = ({1'b0, bus.rd_q} < NQ);
  assign wr_ok     = bus.wr_en && wr_in_rng && !full_x[bus.wr_q];
  assign rd_ok     = bus.rd_en && rd_in_rng && !empty_x[bus.rd_q];
  assign ovf_set   = (bus.wr_en && wr_in_rng && full_x[bus.wr_q])
                     ? (NR_QUEUES'(1) << bus.wr_q) : '0;
  assign udf_set   = (bus.rd_en && rd_in_rng && empty_x[bus.rd_q])
                     ? (NR_QUEUES'(1) << bus.rd_q) : '0;

  vfifo_simple_dpram_sc #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_ok),
    .wr_addr ({bus.wr_q, wr_lo}),
    .wr_data (bus.wr_data),
    .rd_en   (rd_ok),
    .rd_addr ({bus.rd_q, rd_lo}),
    .rd_data (ram_q_p1)
  );

  // p0 -> p1: pointer/flag state and the read-valid that tracks the RAM output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NR_QUEUES; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
      ovf     <= '0;
      udf     <= '0;
      vld_p1  <= 1'b0;
      seen_p1 <= 1'b0;
    end else begin
      for (int i = 0; i < NR_QUEUES; i++) begin
        if (wr_ok && bus.wr_q == QSEL_WIDTH'(i)) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (rd_ok && bus.rd_q == QSEL_WIDTH'(i)) rd_ptr[i] <= rd_ptr[i] + 1'b1;
      end
      ovf     <= bus.err_clr ? '0 : (ovf | ovf_set);
      udf     <= bus.err_clr ? '0 : (udf | udf_set);
      vld_p1  <= rd_ok;
      seen_p1 <= seen_p1 | rd_ok;
    end
  end

  // The RAM output register has no reset; until a word is popped after
  // reset, present zero instead of whatever it holds.
  assign bus.rd_data  = seen_p1 ? ram_q_p1 : '0;
  assign bus.rd_valid = vld_p1;
  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.ovf      = ovf;
  assign bus.udf      = udf;
endmodule
